// File: rtl/lzd_norm_ctrl.sv
// Two-stage leading-zero detector that produces the normalization shift control for an adder result.
// Optional macro NORM_ZERO_DETECT_EN: all-zero input reports zero_o=1 with a zero shift, instead of a shift of SWR-1.
module lzd_norm_ctrl #(
  parameter int unsigned SWR = 26,
  parameter int unsigned EWR = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_i,
  input  logic [SWR-1:0] Data_i,
  output logic [SWR-1:0] Data_o,
  output logic [EWR-1:0] Shift_Value_o,
  output logic           FSM_left_right_o,
  output logic           zero_o,
  output logic           load_o
);

  localparam int unsigned MW = SWR - 1;
  localparam int unsigned NG = (MW + 3) / 4;
  localparam int unsigned PW = NG * 4;

  // Leading-zero count within one 4-bit group; an all-zero group is flagged separately.
  function automatic logic [1:0] lz4(input logic [3:0] n);
    logic [1:0] r;
    r = 2'd0;
    casez (n)
      4'b1???: r = 2'd0;
      4'b01??: r = 2'd1;
      4'b001?: r = 2'd2;
      4'b0001: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  logic                 v1_q, v1_d;
  logic [SWR-1:0]       data1_q, data1_d;
  logic                 carry1_q, carry1_d;
  logic [NG-1:0]        gz_q, gz_d;
  logic [NG-1:0][1:0]   lz_q, lz_d;

  logic                 v2_q, v2_d;
  logic [SWR-1:0]       data2_q, data2_d;
  logic [EWR-1:0]       shift_q, shift_d;
  logic                 dir_q, dir_d;
  logic                 zero_q, zero_d;

  logic [PW-1:0]        mant_pad;
  logic [3:0]           nib;
  logic                 found;
  logic [EWR-1:0]       cnt;

  // Stage 1: group zero flags and local counts; group 0 holds the hidden bit, padding sits below the LSB.
  always_comb begin
    mant_pad = PW'(Data_i[SWR-2:0]) << (PW - MW);
    nib      = 4'd0;
    v1_d     = load_i;
    data1_d  = data1_q;
    carry1_d = carry1_q;
    gz_d     = gz_q;
    lz_d     = lz_q;
    if (load_i) begin
      data1_d  = Data_i;
      carry1_d = Data_i[SWR-1];
      for (int g = 0; g < int'(NG); g++) begin
        nib      = mant_pad[(int'(NG) - 1 - g) * 4 +: 4];
        gz_d[g]  = (nib == 4'd0);
        lz_d[g]  = lz4(nib);
      end
    end
  end

  // Stage 2: first non-zero group from the top gives group*4 + local count.
  always_comb begin
    found   = 1'b0;
    cnt     = '0;
    v2_d    = v1_q;
    data2_d = data2_q;
    shift_d = shift_q;
    dir_d   = dir_q;
    zero_d  = zero_q;
    for (int g = 0; g < int'(NG); g++) begin
      if (!found && !gz_q[g]) begin
        found = 1'b1;
        cnt   = EWR'(4 * g) + EWR'(lz_q[g]);
      end
    end
    if (v1_q) begin
      data2_d = data1_q;
      if (carry1_q) begin
        dir_d   = 1'b0;
        shift_d = EWR'(1);
        zero_d  = 1'b0;
      end else if (found) begin
        dir_d   = 1'b1;
        shift_d = cnt;
        zero_d  = 1'b0;
      end else begin
        dir_d   = 1'b1;
`ifdef NORM_ZERO_DETECT_EN
        shift_d = '0;
        zero_d  = 1'b1;
`else
        shift_d = EWR'(SWR - 1);
        zero_d  = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q     <= 1'b0;
      data1_q  <= '0;
      carry1_q <= 1'b0;
      gz_q     <= '0;
      lz_q     <= '0;
      v2_q     <= 1'b0;
      data2_q  <= '0;
      shift_q  <= '0;
      dir_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      v1_q     <= v1_d;
      data1_q  <= data1_d;
      carry1_q <= carry1_d;
      gz_q     <= gz_d;
      lz_q     <= lz_d;
      v2_q     <= v2_d;
      data2_q  <= data2_d;
      shift_q  <= shift_d;
      dir_q    <= dir_d;
      zero_q   <= zero_d;
    end
  end

  assign Data_o           = data2_q;
  assign Shift_Value_o    = shift_q;
  assign FSM_left_right_o = dir_q;
  assign zero_o           = zero_q;
  assign load_o           = v2_q;

endmodule
